// File: rtl/fb_display_unit_pkg.sv
// Shared constants and instruction layout for the framebuffer display unit.
// Coordinate and address widths are sized for the default 160x120 screen.
package fb_display_unit_pkg;

  localparam int unsigned OPCODE_WIDTH      = 3;
  localparam int unsigned X_COORD_WIDTH     = 8;
  localparam int unsigned Y_COORD_WIDTH     = 7;
  localparam int unsigned INSTRUCTION_WIDTH = Y_COORD_WIDTH + X_COORD_WIDTH + OPCODE_WIDTH;
  localparam int unsigned RESULT_WIDTH      = 8;
  localparam int unsigned FB_ADDR_WIDTH     = 15;

  localparam logic [OPCODE_WIDTH-1:0] OPCODE_DISPLAY = 3'd1;
  localparam logic [RESULT_WIDTH-1:0] RESULT_ERROR   = {1'b1, {(RESULT_WIDTH-1){1'b0}}};

  typedef struct packed {
    logic [Y_COORD_WIDTH-1:0] y;
    logic [X_COORD_WIDTH-1:0] x;
    logic [OPCODE_WIDTH-1:0]  opcode;
  } instr_t;

endpackage

// File: rtl/fb_addr_gen.sv
// Combinational framebuffer address generator: addr = y*SCREEN_W + x,
// built as a sum of shifted y terms for each set bit of SCREEN_W.
module fb_addr_gen
  import fb_display_unit_pkg::*;
#(
  parameter int unsigned SCREEN_W = 160
) (
  input  logic [X_COORD_WIDTH-1:0] x,
  input  logic [Y_COORD_WIDTH-1:0] y,
  output logic [FB_ADDR_WIDTH-1:0] addr
);

  localparam logic [FB_ADDR_WIDTH-1:0] W_BITS = FB_ADDR_WIDTH'(SCREEN_W);

  logic [FB_ADDR_WIDTH-1:0] acc;

  always_comb begin
    acc = FB_ADDR_WIDTH'(x);
    for (int unsigned i = 0; i < FB_ADDR_WIDTH; i++) begin
      if (W_BITS[i]) begin
        acc = acc + (FB_ADDR_WIDTH'(y) << i);
      end
    end
  end

  assign addr = acc;

endmodule

// File: rtl/fb_display_unit.sv
// Framebuffer display unit: reads one pixel from the framebuffer RAM and
// replots it on the VGA port, reporting the colour (or an error) as result.
module fb_display_unit
  import fb_display_unit_pkg::*;
#(
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned SCREEN_H = 120,
  parameter int unsigned COLOUR_W = 3
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [INSTRUCTION_WIDTH-1:0] instruction,
  output logic                         finished,
  output logic [RESULT_WIDTH-1:0]      result,
  output logic [FB_ADDR_WIDTH-1:0]     fb_addr,
  output logic                         fb_rd,
  input  logic [COLOUR_W-1:0]          fb_rdata,
  output logic [X_COORD_WIDTH-1:0]     vga_x,
  output logic [Y_COORD_WIDTH-1:0]     vga_y,
  output logic [COLOUR_W-1:0]          vga_colour,
  output logic                         vga_plot
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_READ_WAIT,
    S_PLOT,
    S_DONE
  } state_t;

  localparam logic [X_COORD_WIDTH:0] X_LIMIT = (X_COORD_WIDTH+1)'(SCREEN_W);
  localparam logic [Y_COORD_WIDTH:0] Y_LIMIT = (Y_COORD_WIDTH+1)'(SCREEN_H);

  state_t                   state_q, state_d;
  instr_t                   instr_q, instr_d;
  logic                     start_prev_q, start_prev_d;
  logic                     err_q, err_d;
  logic [COLOUR_W-1:0]      colour_q, colour_d;
  logic                     finished_q, finished_d;
  logic [RESULT_WIDTH-1:0]  result_q, result_d;
  logic [FB_ADDR_WIDTH-1:0] fb_addr_q, fb_addr_d;
  logic                     fb_rd_q, fb_rd_d;
  logic [X_COORD_WIDTH-1:0] vga_x_q, vga_x_d;
  logic [Y_COORD_WIDTH-1:0] vga_y_q, vga_y_d;
  logic [COLOUR_W-1:0]      vga_colour_q, vga_colour_d;
  logic                     vga_plot_q, vga_plot_d;

  logic [FB_ADDR_WIDTH-1:0] addr_calc;
  logic                     cmd_valid;

  fb_addr_gen #(.SCREEN_W(SCREEN_W)) u_addr_gen (
    .x    (instr_q.x),
    .y    (instr_q.y),
    .addr (addr_calc)
  );

  assign cmd_valid = (instr_q.opcode == OPCODE_DISPLAY) &&
                     ({1'b0, instr_q.x} < X_LIMIT) &&
                     ({1'b0, instr_q.y} < Y_LIMIT);

  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    start_prev_d = start;
    err_d        = err_q;
    colour_d     = colour_q;
    finished_d   = finished_q;
    result_d     = result_q;
    fb_addr_d    = fb_addr_q;
    fb_rd_d      = fb_rd_q;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    vga_plot_d   = vga_plot_q;

    unique case (state_q)
      S_IDLE: begin
        // Only a 0->1 transition of start launches a command.
        if (start && !start_prev_q) begin
          instr_d    = instr_t'(instruction);
          finished_d = 1'b0;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        if (cmd_valid) begin
          fb_addr_d = addr_calc;
          fb_rd_d   = 1'b1;
          err_d     = 1'b0;
          state_d   = S_READ_WAIT;
        end else begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_READ_WAIT: begin
        fb_rd_d = 1'b0;
        state_d = S_PLOT;
      end
      S_PLOT: begin
        colour_d     = fb_rdata;
        vga_x_d      = instr_q.x;
        vga_y_d      = instr_q.y;
        vga_colour_d = fb_rdata;
        vga_plot_d   = 1'b1;
        state_d      = S_DONE;
      end
      S_DONE: begin
        vga_plot_d = 1'b0;
        result_d   = err_q ? RESULT_ERROR : RESULT_WIDTH'(colour_q);
        finished_d = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      instr_q      <= '0;
      start_prev_q <= 1'b0;
      err_q        <= 1'b0;
      colour_q     <= '0;
      finished_q   <= 1'b1;
      result_q     <= '0;
      fb_addr_q    <= '0;
      fb_rd_q      <= 1'b0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      instr_q      <= instr_d;
      start_prev_q <= start_prev_d;
      err_q        <= err_d;
      colour_q     <= colour_d;
      finished_q   <= finished_d;
      result_q     <= result_d;
      fb_addr_q    <= fb_addr_d;
      fb_rd_q      <= fb_rd_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
    end
  end

  assign finished   = finished_q;
  assign result     = result_q;
  assign fb_addr    = fb_addr_q;
  assign fb_rd      = fb_rd_q;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;

endmodule

// File: tb/tb_fb_display_unit.sv
// Directed bench for fb_display_unit: vector table on a 160x120 unit plus
// reset corner cases and a raster sweep on a 4x2 unit.
module tb_fb_display_unit;
  import fb_display_unit_pkg::*;

  logic                         clock;
  logic                         reset;
  logic                         start;
  logic [INSTRUCTION_WIDTH-1:0] instruction;
  logic                         finished;
  logic [RESULT_WIDTH-1:0]      result;
  logic [FB_ADDR_WIDTH-1:0]     fb_addr;
  logic                         fb_rd;
  logic [2:0]                   fb_rdata;
  logic [X_COORD_WIDTH-1:0]     vga_x;
  logic [Y_COORD_WIDTH-1:0]     vga_y;
  logic [2:0]                   vga_colour;
  logic                         vga_plot;

  logic                         start2;
  logic [INSTRUCTION_WIDTH-1:0] instr2;
  logic                         finished2;
  logic [RESULT_WIDTH-1:0]      result2;
  logic [FB_ADDR_WIDTH-1:0]     fb_addr2;
  logic                         fb_rd2;
  logic [2:0]                   fb_rdata2;
  logic [X_COORD_WIDTH-1:0]     vga_x2;
  logic [Y_COORD_WIDTH-1:0]     vga_y2;
  logic [2:0]                   vga_colour2;
  logic                         vga_plot2;

  int          total;
  int          bad;
  int          ram_addr;
  logic [2:0]  ram_data;
  int          rd2_n;

  typedef struct {
    int x;
    int y;
    int c;
  } plot_t;
  plot_t plots[$];

  typedef struct {
    string      nm;
    logic [2:0] op;
    int         x;
    int         y;
    logic [2:0] data;
    int         addr;
    bit         ok;
    int         hold;
    int         res;
  } vec_t;
  vec_t vecs[10];

  fb_display_unit #(.SCREEN_W(160), .SCREEN_H(120), .COLOUR_W(3)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .instruction (instruction),
    .finished    (finished),
    .result      (result),
    .fb_addr     (fb_addr),
    .fb_rd       (fb_rd),
    .fb_rdata    (fb_rdata),
    .vga_x       (vga_x),
    .vga_y       (vga_y),
    .vga_colour  (vga_colour),
    .vga_plot    (vga_plot)
  );

  fb_display_unit #(.SCREEN_W(4), .SCREEN_H(2), .COLOUR_W(3)) dut_small (
    .clock       (clock),
    .reset       (reset),
    .start       (start2),
    .instruction (instr2),
    .finished    (finished2),
    .result      (result2),
    .fb_addr     (fb_addr2),
    .fb_rd       (fb_rd2),
    .fb_rdata    (fb_rdata2),
    .vga_x       (vga_x2),
    .vga_y       (vga_y2),
    .vga_colour  (vga_colour2),
    .vga_plot    (vga_plot2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous RAM models: data appears one edge after the read is sampled.
  always @(posedge clock) begin
    if (fb_rd) fb_rdata <= (int'(fb_addr) == ram_addr) ? ram_data : 3'b010;
    if (fb_rd2) fb_rdata2 <= 3'(fb_addr2 + 15'd1);
  end

  always @(negedge clock) begin
    if (vga_plot2) plots.push_back('{int'(vga_x2), int'(vga_y2), int'(vga_colour2)});
    if (fb_rd2) rd2_n++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic run_cmd(input vec_t v);
    int lat;
    int rd_n;
    int plot_n;
    int drop;
    lat = -1; rd_n = 0; plot_n = 0; drop = 0;
    ram_addr    = v.addr;
    ram_data    = v.data;
    instruction = {7'(v.y), 8'(v.x), v.op};
    start       = 1'b1;
    @(posedge clock); #1;
    check({v.nm, "_busy"}, int'(finished), 0);
    for (int c = 1; c <= 16; c++) begin
      @(posedge clock); #1;
      if (c >= v.hold - 1) start = 1'b0;
      if (fb_rd) begin
        rd_n++;
        check({v.nm, "_addr"}, int'(fb_addr), v.addr);
      end
      if (vga_plot) begin
        plot_n++;
        check({v.nm, "_vx"}, int'(vga_x), v.x);
        check({v.nm, "_vy"}, int'(vga_y), v.y);
        check({v.nm, "_vcol"}, int'(vga_colour), int'(v.data));
      end
      if (finished && lat < 0) lat = c;
      if (!finished && lat >= 0) drop++;
    end
    check({v.nm, "_latency"}, lat, v.ok ? 4 : 2);
    check({v.nm, "_rd_count"}, rd_n, v.ok ? 1 : 0);
    check({v.nm, "_plot_count"}, plot_n, v.ok ? 1 : 0);
    check({v.nm, "_retrigger"}, drop, 0);
    check({v.nm, "_result"}, int'(result), v.res);
  endtask

  initial begin
    vec_t v;
    int   k;
    total = 0; bad = 0; rd2_n = 0;
    ram_addr = 0; ram_data = 3'd0;
    fb_rdata = 3'd0; fb_rdata2 = 3'd0;
    start = 1'b0; instruction = '0;
    start2 = 1'b0; instr2 = '0;

    vecs[0] = '{"disp_5_2",    3'd1,   5,   2, 3'd5,   325, 1'b1,  2,   5};
    vecs[1] = '{"corner",      3'd1, 159, 119, 3'd6, 19199, 1'b1,  2,   6};
    vecs[2] = '{"origin",      3'd1,   0,   0, 3'd3,     0, 1'b1,  2,   3};
    vecs[3] = '{"bad_op",      3'd2,   5,   2, 3'd5,   325, 1'b0,  2, 128};
    vecs[4] = '{"x_160",       3'd1, 160,   0, 3'd5,   160, 1'b0,  2, 128};
    vecs[5] = '{"y_120",       3'd1,   0, 120, 3'd5, 19200, 1'b0,  2, 128};
    vecs[6] = '{"hold10",      3'd1,  10, 100, 3'd7, 16010, 1'b1, 10,   7};
    vecs[7] = '{"op_zero",     3'd0,   1,   1, 3'd7,   161, 1'b0,  2, 128};
    vecs[8] = '{"right_edge",  3'd1, 159,   0, 3'd1,   159, 1'b1,  2,   1};
    vecs[9] = '{"bottom_edge", 3'd1,   0, 119, 3'd4, 19040, 1'b1,  2,   4};

    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_finished", int'(finished), 1);
    check("rst_result", int'(result), 0);
    check("rst_fb_rd", int'(fb_rd), 0);
    check("rst_fb_addr", int'(fb_addr), 0);
    check("rst_plot", int'(vga_plot), 0);
    check("rst_vx", int'(vga_x), 0);
    check("rst_vy", int'(vga_y), 0);
    check("rst_vcol", int'(vga_colour), 0);

    // start already high when reset releases must count as a rising edge
    instruction = {7'd1, 8'd1, OPCODE_DISPLAY};
    start = 1'b1;
    #1 reset = 1'b0;
    run_cmd('{"start_at_release", 3'd1, 1, 1, 3'd3, 161, 1'b1, 2, 3});

    foreach (vecs[i]) run_cmd(vecs[i]);

    ram_addr = 484; ram_data = 3'd5;
    instruction = {7'd3, 8'd4, OPCODE_DISPLAY};
    start = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    start = 1'b0;
    check("mid_fb_rd", int'(fb_rd), 1);
    reset = 1'b1;
    #1;
    check("mid_rst_finished", int'(finished), 1);
    check("mid_rst_plot", int'(vga_plot), 0);
    check("mid_rst_fb_rd", int'(fb_rd), 0);
    check("mid_rst_result", int'(result), 0);
    @(posedge clock); #1;
    reset = 1'b0;
    run_cmd('{"after_rst", 3'd1, 20, 30, 3'd6, 4820, 1'b1, 2, 6});

    for (int y = 0; y < 2; y++) begin
      for (int x = 0; x < 4; x++) begin
        instr2 = {7'(y), 8'(x), OPCODE_DISPLAY};
        start2 = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        start2 = 1'b0;
        k = 0;
        while (!finished2 && k < 12) begin
          @(posedge clock); #1;
          k++;
        end
        check("sweep_finished", int'(finished2), 1);
        check("sweep_result", int'(result2), (y * 4 + x + 1) % 8);
      end
    end
    repeat (3) @(posedge clock);
    #1;
    check("sweep_plot_count", plots.size(), 8);
    check("sweep_rd_count", rd2_n, 8);
    for (int i = 0; i < 8; i++) begin
      if (i < plots.size()) begin
        check("sweep_px", plots[i].x, i % 4);
        check("sweep_py", plots[i].y, i / 4);
        check("sweep_pc", plots[i].c, (i + 1) % 8);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
